prog_loader: RTL and testbench
==============================

# prog_loader

FPGA-demo controller that boots `tt_um_tiny_processor` from a local program ROM. On a start pulse it drives the processor's 2-bit mode input and streams instruction words, then register-init words, serially over the `cs`/`mosi` pins. Each word is handshaked against the processor's `done` strobe. When loading finishes it switches the processor to run mode. It replaces the simulation-only driver and sits between the board ROM and the processor's `uio_in`/`uio_out` pins.

## Interface
- `N_INSTR`, 16, number of instruction words loaded (phase 1)
- `N_REGS`, 16, number of register-init words loaded (phase 2)
- `WORD_W`, 8, bits per serial word
- `DONE_TIMEOUT`, 255, maximum WAIT_DONE cycles before abort (only with `PROG_LOADER_TIMEOUT_EN`)
- `clk`  in  1  system clock; also the serial bit clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  single-cycle load request
- `rom_addr`  out  $clog2(N_INSTR+N_REGS)  ROM address; instructions at 0..N_INSTR-1, registers follow
- `rom_data`  in  WORD_W  ROM data, valid one cycle after `rom_addr`
- `mode_out`  out  2  processor mode: 00 idle, 01 load instr, 10 load regs, 11 run
- `cs`  out  1  serial select, active-low
- `mosi`  out  1  serial data, MSB first
- `done_in`  in  1  processor word-accepted strobe
- `busy`  out  1  high in any state except IDLE/RUN
- `load_done`  out  1  high while in RUN
- `err`  out  1  sticky timeout flag

## Operation
- States: IDLE, FETCH, SHIFT, WAIT_DONE, RUN.
- Reset values: state IDLE, `mode_out`=00, `cs`=1, `mosi`=0, `rom_addr`=0, `busy`=0, `load_done`=0, `err`=0.
- IDLE or RUN + `start` → FETCH, `mode_out`=01, word index 0, `err` cleared.
- `start` in FETCH/SHIFT/WAIT_DONE is ignored.
- FETCH (1 cycle): `rom_addr` = phase base + index.
- FETCH → SHIFT: `rom_data` is loaded into the shift register and `cs` goes low.
- SHIFT (WORD_W cycles): `mosi` = shift-register MSB; shift left each cycle; 3-bit bit counter.
- After the last bit: `cs` returns high, `mosi` returns 0, go to WAIT_DONE.
- WAIT_DONE + `done_in`:
  - not last word in phase → index+1, go to FETCH.
  - last instruction word → `mode_out`=10, index 0, go to FETCH.
  - last register word → `mode_out`=11, go to RUN.
- `done_in` outside WAIT_DONE is ignored.
- RUN: `mode_out` held at 11, `load_done`=1, `cs`=1; only `start` or reset leaves RUN.
- `rst_n` low at any point, including mid-word: next edge forces reset values and the partial word is abandoned.
- `N_INSTR`=0 or `N_REGS`=0 is unsupported; both must be ≥1.

## Timing
- `mode_out`=01 and `busy`=1 appear on the edge after `start` is sampled.
- Per word: 1 FETCH + WORD_W SHIFT + k WAIT_DONE cycles, k≥1.
- `done_in` is sampled from the first WAIT_DONE cycle, so the minimum is WORD_W+2 cycles per word.
- Minimum start-to-`mode_out`=11: (N_INSTR+N_REGS)·(WORD_W+2) cycles after the start edge; 320 at defaults.
- `cs` is low for exactly WORD_W consecutive cycles per word.
- The mode switch 01→10 occurs on the same edge that enters the first register-word FETCH.

## Configuration
- `PROG_LOADER_TIMEOUT_EN` defined:
  - WAIT_DONE cycle counter resets on entry.
  - Reaching DONE_TIMEOUT without `done_in` sets `err`=1 and returns to IDLE with `mode_out`=00 and `cs`=1.
  - `done_in` arriving in the same cycle as the timeout wins: the word is accepted.
- `PROG_LOADER_TIMEOUT_EN` undefined:
  - WAIT_DONE waits indefinitely.
  - `err` is tied 0 and no counter is instantiated.

## Structure
- `prog_loader_pkg`: state enum, mode constants (`MODE_IDLE`, `MODE_LD_INSTR`, `MODE_LD_REGS`, `MODE_RUN`).
- One sub-module, `prog_loader_shift`: WORD_W shift register plus bit counter.
  - Inputs: `load`, `data`.
  - Outputs: `mosi`, `last_bit`.

## Test plan
- Reset, `start`, device model asserts `done_in` 1 cycle after each word → 32 words, each bit-exact to ROM contents, MSB first; `mode_out` 01 for 16 words, then 10; `mode_out`=11 and `load_done`=1 exactly 320 cycles after start.
- `done_in` delayed 5 cycles on word 3 → `cs` stays high, no new FETCH until `done_in`; total time +4 cycles.
- `start` pulsed during SHIFT and again in RUN → first pulse ignored; second restarts with `mode_out`=01 and index 0.
- `rst_n` low for 1 cycle mid-SHIFT of word 7 → next cycle: `cs`=1, `mode_out`=00, `busy`=0; fresh `start` reloads from word 0.
- With `PROG_LOADER_TIMEOUT_EN`, `DONE_TIMEOUT`=10, device never strobes → `err`=1 and IDLE 10 cycles into WAIT_DONE of word 0; next `start` clears `err`.
- Spurious `done_in` during FETCH/SHIFT → no index advance; word count and data unchanged.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   state_e      : loader FSM states
//   MODE_*       : encodings driven onto the processor's 2-bit mode input
package prog_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SHIFT,
      S_WAIT,
      S_RUN
   } state_e;

   localparam logic [1:0] MODE_IDLE     = 2'b00;
   localparam logic [1:0] MODE_LD_INSTR = 2'b01;
   localparam logic [1:0] MODE_LD_REGS  = 2'b10;
   localparam logic [1:0] MODE_RUN      = 2'b11;

endpackage

// File: rtl/prog_loader_shift.sv
// prog_loader_shift: WORD_W-bit parallel-in / serial-out shift register, MSB first.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load        capture data, clear bit counter
//   en          shift left one bit, advance bit counter
//   data        parallel word
//   mosi        current MSB of the shift register
//   last_bit    the bit currently on mosi is the final bit of the word
module prog_loader_shift #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              en,
   input  logic [WORD_W-1:0] data,
   output logic              mosi,
   output logic              last_bit
);

   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   logic [WORD_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load) begin
         sr_d  = data;
         cnt_d = '0;
      end else if (en) begin
         sr_d  = {sr_q[WORD_W-2:0], 1'b0};
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign mosi     = sr_q[WORD_W-1];
   assign last_bit = (cnt_q == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boots tt_um_tiny_processor from a local program ROM.
// On start, loads N_INSTR instruction words (mode 01) then N_REGS register words
// (mode 10) serially over cs/mosi, each handshaked by done_in, then enters run (mode 11).
// Ports:
//   clk, rst_n   clock (also serial bit clock), synchronous active-low reset
//   start        single-cycle load request, honoured in IDLE or RUN
//   rom_addr     ROM address (instructions first, register words follow)
//   rom_data     ROM data, sampled at the end of the FETCH cycle
//   mode_out     processor mode
//   cs, mosi     serial select (active low) and data, MSB first
//   done_in      processor word-accepted strobe, sampled only in WAIT_DONE
//   busy         loading in progress
//   load_done    high while in RUN
//   err          sticky done_in timeout flag
// Optional feature: define PROG_LOADER_TIMEOUT_EN to abort a load when done_in does
// not arrive within DONE_TIMEOUT WAIT_DONE cycles; otherwise err is tied low.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int N_INSTR      = 16,
   parameter int N_REGS       = 16,
   parameter int WORD_W       = 8,
   parameter int DONE_TIMEOUT = 255
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   output logic [$clog2(N_INSTR+N_REGS)-1:0]   rom_addr,
   input  logic [WORD_W-1:0]                   rom_data,
   output logic [1:0]                          mode_out,
   output logic                                cs,
   output logic                                mosi,
   input  logic                                done_in,
   output logic                                busy,
   output logic                                load_done,
   output logic                                err
);

   localparam int AW = $clog2(N_INSTR + N_REGS);

   state_e          state_q, state_d;
   logic [1:0]      mode_q, mode_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            sh_load, sh_en, sh_mosi, sh_last;
   logic            last_word;
   logic            start_acc;
   logic            tmo_fire;

   // Last word of the current phase; the phase is implied by mode_q.
   assign last_word = (mode_q == MODE_LD_INSTR) ? (idx_q == AW'(N_INSTR - 1))
                                                : (idx_q == AW'(N_REGS - 1));

   assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_RUN));

`ifdef PROG_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(DONE_TIMEOUT + 1);

   logic [TW-1:0] tmo_q;
   logic          err_q;

   // done_in in the timeout cycle takes priority, so it gates the abort.
   assign tmo_fire = (state_q == S_WAIT) && !done_in && (tmo_q == TW'(DONE_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= (state_q == S_WAIT) ? tmo_q + 1'b1 : '0;
         if (start_acc)     err_q <= 1'b0;
         else if (tmo_fire) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_tmo;
   assign tmo_fire   = 1'b0;
   assign unused_tmo = (DONE_TIMEOUT != 0);
   assign err        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      sh_load = 1'b0;
      sh_en   = 1'b0;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (start_acc) begin
               state_d = S_FETCH;
               mode_d  = MODE_LD_INSTR;
               idx_d   = '0;
               addr_d  = '0;
            end
         end
         S_FETCH: begin
            sh_load = 1'b1;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            sh_en = 1'b1;
            if (sh_last) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (done_in) begin
               if (!last_word) begin
                  idx_d   = idx_q + 1'b1;
                  addr_d  = addr_q + 1'b1;
                  state_d = S_FETCH;
               end else if (mode_q == MODE_LD_INSTR) begin
                  // Register words sit directly after the instructions in ROM.
                  mode_d  = MODE_LD_REGS;
                  idx_d   = '0;
                  addr_d  = AW'(N_INSTR);
                  state_d = S_FETCH;
               end else begin
                  mode_d  = MODE_RUN;
                  state_d = S_RUN;
               end
            end else if (tmo_fire) begin
               mode_d  = MODE_IDLE;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
      end
   end

   prog_loader_shift #(.WORD_W(WORD_W)) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sh_load),
      .en       (sh_en),
      .data     (rom_data),
      .mosi     (sh_mosi),
      .last_bit (sh_last)
   );

   // cs is low exactly for the WORD_W SHIFT cycles; mosi is forced 0 elsewhere.
   assign cs        = (state_q != S_SHIFT);
   assign mosi      = (state_q == S_SHIFT) && sh_mosi;
   assign rom_addr  = addr_q;
   assign mode_out  = mode_q;
   assign busy      = (state_q == S_FETCH) || (state_q == S_SHIFT) || (state_q == S_WAIT);
   assign load_done = (state_q == S_RUN);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [4:0] rom_addr;
   logic [7:0] rom_data;
   logic [1:0] mode_out;
   logic       cs, mosi, done_in, busy, load_done, err;
   logic       done_tb, done_resp;

   int checks = 0;
   int errors = 0;

   logic [7:0] rom [0:31];
   assign rom_data = rom[rom_addr];
   assign done_in  = done_tb | done_resp;

   always #5 clk = ~clk;

`ifdef PROG_LOADER_TIMEOUT_EN
   prog_loader #(.N_INSTR(16), .N_REGS(16), .WORD_W(8), .DONE_TIMEOUT(10)) dut (
`else
   prog_loader #(.N_INSTR(16), .N_REGS(16), .WORD_W(8)) dut (
`endif
      .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .mode_out(mode_out), .cs(cs), .mosi(mosi), .done_in(done_in), .busy(busy),
      .load_done(load_done), .err(err));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Serial capture: one word per 8 cs-low cycles, tagged with mode at its last bit.
   logic [7:0] cur;
   int         nb = 0;
   logic [7:0] cap_w[$];
   logic [1:0] cap_m[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         nb = 0;
      end else if (!cs) begin
         cur = {cur[6:0], mosi};
         nb++;
         if (nb == 8) begin
            cap_w.push_back(cur);
            cap_m.push_back(mode_out);
            nb = 0;
         end
      end else if (nb != 0) begin
         checks++;
         errors++;
         $display("FAIL cs_low_len actual=%0d expected=8", nb);
         nb = 0;
      end
   end

   // Device model: strobe done_in k WAIT cycles after cs rises (k=1, or 5 on dly_word).
   bit   resp_en  = 1'b0;
   int   dly_word = -1;
   int   widx     = 0;
   int   wcnt     = 0;
   bit   waiting  = 1'b0;
   logic cs_prev  = 1'b1;

   always @(negedge clk) begin
      done_resp = 1'b0;
      if (!rst_n || !resp_en) begin
         waiting = 1'b0;
      end else begin
         if (!cs_prev && cs) begin
            waiting = 1'b1;
            wcnt    = 0;
         end
         if (waiting) begin
            wcnt++;
            if (wcnt >= ((widx == dly_word) ? 5 : 1)) begin
               done_resp = 1'b1;
               waiting   = 1'b0;
               widx++;
            end
         end
      end
      cs_prev = cs;
   end

   typedef struct {
      logic       rst_n, start, done;
      logic       cs, mosi;
      logic [1:0] mode;
      logic       busy, ld;
      logic [4:0] addr;
   } vec_t;

   vec_t tv[16];

   task automatic setv(input int i, input logic r, input logic s, input logic d,
                       input logic c, input logic m, input logic [1:0] md,
                       input logic b, input logic l, input logic [4:0] a);
      tv[i].rst_n = r; tv[i].start = s; tv[i].done = d;
      tv[i].cs = c; tv[i].mosi = m; tv[i].mode = md;
      tv[i].busy = b; tv[i].ld = l; tv[i].addr = a;
   endtask

   // Full load from start pulse to RUN; pulse_at re-pulses start mid-load.
   task automatic run_load(input string tag, input int dly, input int pulse_at, input int exp_cyc);
      int cyc;
      cap_w.delete();
      cap_m.delete();
      widx     = 0;
      dly_word = dly;
      resp_en  = 1'b1;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      chk({tag, "_start_mode"}, 32'(mode_out), 32'd1);
      chk({tag, "_start_busy"}, 32'(busy), 32'd1);
      chk({tag, "_start_addr"}, 32'(rom_addr), 32'd0);
      chk({tag, "_start_ld"}, 32'(load_done), 32'd0);
      while (mode_out != 2'b11 && cyc < 2000) begin
         start = (cyc == pulse_at);
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_run_ld"}, 32'({load_done, busy, cs}), 32'b101);
      chk({tag, "_nwords"}, 32'(cap_w.size()), 32'd32);
      for (int i = 0; i < 32 && i < cap_w.size(); i++) begin
         chk($sformatf("%s_word%0d", tag, i), 32'({cap_m[i], cap_w[i]}),
             32'({(i < 16) ? 2'b01 : 2'b10, rom[i]}));
      end
      resp_en = 1'b0;
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 32; i++) rom[i] = 8'(i * 29 + 7);
      rom[0] = 8'hA5;
      rom[1] = 8'hC3;
      rst_n   = 1'b0;
      start   = 1'b0;
      done_tb = 1'b0;

      //        rst st dn   cs mosi mode busy ld addr
      setv( 0, 0, 0, 0,   1, 0, 2'd0, 0, 0, 5'd0);  // reset
      setv( 1, 1, 0, 0,   1, 0, 2'd0, 0, 0, 5'd0);
      setv( 2, 1, 0, 1,   1, 0, 2'd0, 0, 0, 5'd0);  // done_in in IDLE ignored
      setv( 3, 1, 1, 0,   1, 0, 2'd1, 1, 0, 5'd0);  // start -> FETCH
      setv( 4, 1, 0, 1,   0, 1, 2'd1, 1, 0, 5'd0);  // SHIFT, A5 bit7; stray done
      setv( 5, 1, 0, 1,   0, 0, 2'd1, 1, 0, 5'd0);  // bit6, stray done
      setv( 6, 1, 1, 0,   0, 1, 2'd1, 1, 0, 5'd0);  // bit5, start ignored
      setv( 7, 1, 0, 0,   0, 0, 2'd1, 1, 0, 5'd0);  // bit4
      setv( 8, 1, 0, 0,   0, 0, 2'd1, 1, 0, 5'd0);  // bit3
      setv( 9, 1, 0, 0,   0, 1, 2'd1, 1, 0, 5'd0);  // bit2
      setv(10, 1, 0, 0,   0, 0, 2'd1, 1, 0, 5'd0);  // bit1
      setv(11, 1, 0, 0,   0, 1, 2'd1, 1, 0, 5'd0);  // bit0
      setv(12, 1, 0, 0,   1, 0, 2'd1, 1, 0, 5'd0);  // WAIT_DONE
      setv(13, 1, 0, 1,   1, 0, 2'd1, 1, 0, 5'd1);  // done -> FETCH word 1
      setv(14, 1, 0, 0,   0, 1, 2'd1, 1, 0, 5'd1);  // SHIFT, C3 bit7
      setv(15, 0, 0, 0,   1, 0, 2'd0, 0, 0, 5'd0);  // reset mid-word

      for (int i = 0; i < 16; i++) begin
         rst_n   = tv[i].rst_n;
         start   = tv[i].start;
         done_tb = tv[i].done;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d", i), 32'({cs, mosi, mode_out, busy, load_done, rom_addr}),
             32'({tv[i].cs, tv[i].mosi, tv[i].mode, tv[i].busy, tv[i].ld, tv[i].addr}));
      end
      rst_n   = 1'b1;
      start   = 1'b0;
      done_tb = 1'b0;
      @(posedge clk);
      @(negedge clk);

      run_load("base", -1, -1, 320);
      chk("err_base", 32'(err), 32'd0);
      // restart from RUN, start pulse during word-0 SHIFT, slow done on word 3
      run_load("dly", 3, 3, 324);

      // reset mid-SHIFT of word 7
      cap_w.delete();
      cap_m.delete();
      widx    = 0;
      dly_word = -1;
      resp_en = 1'b1;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (cyc < 74) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_out", 32'({cs, mode_out, busy, load_done, rom_addr}), 32'({1'b1, 2'b00, 1'b0, 1'b0, 5'd0}));
      chk("rst_mid_words", 32'(cap_w.size()), 32'd7);
      rst_n   = 1'b1;
      resp_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      run_load("reload", -1, -1, 320);

`ifdef PROG_LOADER_TIMEOUT_EN
      resp_en = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (cyc < 18) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      chk("tmo_before", 32'({busy, err}), 32'b10);
      @(posedge clk);
      @(negedge clk);
      chk("tmo_abort", 32'({busy, err, mode_out, cs}), 32'({1'b0, 1'b1, 2'b00, 1'b1}));
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("tmo_clear", 32'({err, mode_out}), 32'({1'b0, 2'b01}));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
